// File: rtl/video_timing_gen.sv
// Free-running raster timing generator: hs/vs/de plus raw h/v counters for one static video mode.
// Latency: hs/vs/de lag h_cnt/v_cnt by exactly one ce cycle; ce=0 freezes every register.
// No backpressure; VTG_FRAME_CNT_EN adds an 8-bit wrapping frame counter (tied 0 otherwise).
module video_timing_gen #(
  parameter int   H_ACTIVE = 1920,
  parameter int   H_FP     = 88,
  parameter int   H_SYNC   = 44,
  parameter int   H_BP     = 148,
  parameter int   V_ACTIVE = 1080,
  parameter int   V_FP     = 4,
  parameter int   V_SYNC   = 5,
  parameter int   V_BP     = 36,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  output logic        hs,
  output logic        vs,
  output logic        de,
  output logic [11:0] h_cnt,
  output logic [11:0] v_cnt,
  output logic [7:0]  frame_cnt
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);

  // Window bounds are 13 bits so an active window ending exactly at 4096 still compares correctly.
  localparam logic [12:0] H_SYNC_END = 13'(H_SYNC);
  localparam logic [12:0] H_ACT_BEG  = 13'(H_SYNC + H_BP);
  localparam logic [12:0] H_ACT_END  = 13'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [12:0] V_SYNC_END = 13'(V_SYNC);
  localparam logic [12:0] V_ACT_BEG  = 13'(V_SYNC + V_BP);
  localparam logic [12:0] V_ACT_END  = 13'(V_SYNC + V_BP + V_ACTIVE);

  logic        h_wrap;
  logic        v_wrap;
  logic        h_in_sync;
  logic        v_in_sync;
  logic        h_in_act;
  logic        v_in_act;
  logic [12:0] h_ext;
  logic [12:0] v_ext;

  always_comb begin
    h_ext     = {1'b0, h_cnt};
    v_ext     = {1'b0, v_cnt};
    h_wrap    = (h_cnt == H_LAST);
    v_wrap    = (v_cnt == V_LAST);
    h_in_sync = (h_ext < H_SYNC_END);
    v_in_sync = (v_ext < V_SYNC_END);
    h_in_act  = (h_ext >= H_ACT_BEG) && (h_ext < H_ACT_END);
    v_in_act  = (v_ext >= V_ACT_BEG) && (v_ext < V_ACT_END);
  end

  // Outputs decode the counter values present before this ce edge, giving the fixed one-cycle lag.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
      hs    <= ~HS_POL;
      vs    <= ~VS_POL;
      de    <= 1'b0;
    end else if (ce) begin
      h_cnt <= h_wrap ? 12'd0 : h_cnt + 12'd1;
      if (h_wrap) begin
        v_cnt <= v_wrap ? 12'd0 : v_cnt + 12'd1;
      end
      hs <= h_in_sync ? HS_POL : ~HS_POL;
      vs <= v_in_sync ? VS_POL : ~VS_POL;
      de <= h_in_act && v_in_act;
    end
  end

`ifdef VTG_FRAME_CNT_EN
  // Advances on the same edge that returns v_cnt to 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (ce && h_wrap && v_wrap) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen in a small mode (H_TOTAL=15, V_TOTAL=8); reference is position arithmetic.
module tb_video_timing_gen;

  localparam int HA = 8, HFP = 2, HSW = 3, HBP = 2;
  localparam int VA = 4, VFP = 1, VSW = 2, VBP = 1;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FT = HT * VT;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce  = 1'b0;
  logic        hs, vs, de;
  logic [11:0] h_cnt, v_cnt;
  logic [7:0]  frame_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int t       = 0;  // ce cycles elapsed since last reset

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .ce(ce),
    .hs(hs), .vs(vs), .de(de),
    .h_cnt(h_cnt), .v_cnt(v_cnt), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] obs, input int exp);
    n_tests++;
    assert (obs === 12'(exp)) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d (t=%0d)", tag, obs, exp, t);
    end
  endtask

  // Reference: position p in the raster is simply t mod frame length.
  task automatic check_all();
    int p, q, eh, ev, ehs, evs, ede, ef;
    p  = t % FT;
    eh = p % HT;
    ev = p / HT;
    if (t == 0) begin
      ehs = 1; evs = 0; ede = 0;
    end else begin
      q   = (t - 1) % FT;
      ehs = ((q % HT) < HSW) ? 0 : 1;
      evs = ((q / HT) < VSW) ? 1 : 0;
      ede = ((q % HT) >= HSW + HBP && (q % HT) < HSW + HBP + HA &&
             (q / HT) >= VSW + VBP && (q / HT) < VSW + VBP + VA) ? 1 : 0;
    end
`ifdef VTG_FRAME_CNT_EN
    ef = (t / FT) % 256;
`else
    ef = 0;
`endif
    chk("h_cnt", h_cnt, eh);
    chk("v_cnt", v_cnt, ev);
    chk("hs", 12'(hs), ehs);
    chk("vs", 12'(vs), evs);
    chk("de", 12'(de), ede);
    chk("frame_cnt", 12'(frame_cnt), ef);
  endtask

  task automatic step(input logic r, input logic c);
    rst = r;
    ce  = c;
    @(posedge clk);
    #1;
    if (r) t = 0;
    else if (c) t++;
    check_all();
  endtask

  initial begin
    int de_clks, de_runs, hs_low, vs_high, hs_falls;
    logic prev_de, prev_hs;

    // Reset held for two clocks
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);

    // One full frame with ce=1, gathering waveform statistics
    de_clks = 0; de_runs = 0; hs_low = 0; vs_high = 0; hs_falls = 0;
    prev_de = 1'b0; prev_hs = 1'b1;
    for (int i = 0; i < FT; i++) begin
      step(1'b0, 1'b1);
      if (i == 0) chk("vs_rise_with_hs_fall", {10'd0, vs, hs}, 2);
      if (de) de_clks++;
      if (de && !prev_de) de_runs++;
      if (!hs) hs_low++;
      if (!hs && prev_hs) hs_falls++;
      if (vs) vs_high++;
      prev_de = de;
      prev_hs = hs;
    end
    chk("de_clks_per_frame", 12'(de_clks), VA * HA);
    chk("de_runs_per_frame", 12'(de_runs), VA);
    chk("hs_low_clks", 12'(hs_low), VT * HSW);
    chk("hs_pulses", 12'(hs_falls), VT);
    chk("vs_high_clks", 12'(vs_high), VSW * HT);

    // ce alternating: same raster stretched x2, holds on ce=0
    step(1'b1, 1'b0);
    de_clks = 0;
    for (int i = 0; i < 2 * FT; i++) begin
      step(1'b0, (i % 2) == 0);
      if (de) de_clks++;
    end
    chk("de_clks_stretched", 12'(de_clks), 2 * VA * HA);

    // Mid-line reset at h=9, v=5
    step(1'b1, 1'b0);
    for (int i = 0; i < 5 * HT + 9; i++) step(1'b0, 1'b1);
    chk("pre_rst_h", h_cnt, 9);
    chk("pre_rst_v", v_cnt, 5);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);

    // Randomized ce with occasional resets
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 63) == 0), 1'($urandom_range(0, 1)));
    end

    // 257 frames: frame counter wraps through 255 -> 0 -> 1
    step(1'b1, 1'b0);
    for (int i = 0; i < 257 * FT; i++) step(1'b0, 1'b1);
`ifdef VTG_FRAME_CNT_EN
    chk("frame_cnt_after_257", 12'(frame_cnt), 1);
`else
    chk("frame_cnt_after_257", 12'(frame_cnt), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
